// File: rtl/bcd_seq_multiplier.sv
// bcd_seq_multiplier
//   Sequential DIGITS x DIGITS BCD mantissa multiplier (shift-and-add, one
//   multiplier digit per pass). The BCD addition itself is done by an
//   external combinational BCD adder: this block drives its operands
//   (add_a/add_b) and consumes its result (add_sum/add_carry).
//
//   Optional build macro: BCD_MULT_INPUT_CHECK_EN
//     defined   : non-BCD nibbles on an accepted start abort the multiply;
//                 product is forced to 0 and err is raised.
//     undefined : no check, err tied low.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      1-cycle request, accepted only in IDLE while done is low
//   mcand      multiplicand (BCD), captured on accept
//   mplier     multiplier (BCD), captured on accept
//   busy       high while the multiply is iterating (ADD/SHIFT)
//   done       1-cycle pulse, product valid
//   product    2*DIGITS-digit BCD product, held until the next completion
//   add_a      adder operand M1: accumulator high half
//   add_b      adder operand M2: multiplicand during ADD, else 0
//   add_sum    adder result Mr
//   add_carry  adder carry; only bit 0 is meaningful
//   err        non-BCD input flag (see macro above)
//
// State | meaning
//   IDLE  | waiting for start
//   ADD   | accumulate multiplicand into HI, once per unit of current digit
//   SHIFT | shift {CY,HI,LO} right one digit, load next multiplier digit
//   DONE  | register product and pulse done
module bcd_seq_multiplier #(
  parameter int DIGITS = 14,
  localparam int W = 4 * DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     mcand,
  input  logic [W-1:0]     mplier,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_sum,
  input  logic [3:0]       add_carry,
  output logic             err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    mc, mp, hi, lo;
  logic [3:0]      cy, cnt;
  logic [IW-1:0]   idx;
  logic            accept, bad_input;
  logic            unused_bits;

  // A start coinciding with the done pulse is deliberately dropped.
  assign accept = (state == IDLE) && start && !done;

  // Only bit 0 of the carry is meaningful; mp[3:0] is consumed via the
  // look-ahead of mp[7:4] during SHIFT.
  assign unused_bits = ^{add_carry[3:1], mp[3:0]};

`ifdef BCD_MULT_INPUT_CHECK_EN
  logic err_r;

  always_comb begin
    bad_input = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((mcand[4*i +: 4] > 4'd9) || (mplier[4*i +: 4] > 4'd9)) bad_input = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_r <= 1'b0;
    else if (accept) err_r <= bad_input;
  end

  assign err = err_r;
`else
  assign bad_input = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          // A rejected operand runs one SHIFT of zeros as the final digit,
          // reaching DONE with a zero product.
          if (bad_input) state_nxt = SHIFT;
          else state_nxt = (mplier[3:0] != 4'd0) ? ADD : SHIFT;
        end
      end
      ADD: begin
        if (cnt == 4'd1) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (idx == LAST) state_nxt = DONE;
        else state_nxt = (mp[7:4] != 4'd0) ? ADD : SHIFT;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc      <= '0;
      mp      <= '0;
      hi      <= '0;
      lo      <= '0;
      cy      <= '0;
      cnt     <= '0;
      idx     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mc  <= mcand;
            mp  <= mplier;
            hi  <= '0;
            lo  <= '0;
            cy  <= '0;
            cnt <= mplier[3:0];
            idx <= bad_input ? LAST : '0;
          end
        end
        ADD: begin
          hi  <= add_sum;
          // Accumulator stays below 10^(DIGITS+1), so CY never exceeds 9.
          cy  <= cy + {3'b000, add_carry[0]};
          cnt <= cnt - 4'd1;
        end
        SHIFT: begin
          lo <= {hi[3:0], lo[W-1:4]};
          hi <= {cy, hi[W-1:4]};
          cy <= '0;
          mp <= mp >> 4;
          if (idx != LAST) begin
            idx <= idx + 1'b1;
            cnt <= mp[7:4];
          end
        end
        DONE: begin
          product <= {hi, lo};
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == ADD) || (state == SHIFT);
  assign add_a = hi;
  assign add_b = (state == ADD) ? mc : '0;

endmodule

// File: tb/tb_bcd_seq_multiplier.sv
module tb_bcd_seq_multiplier;
  localparam int D = 14;
  localparam int W = 4 * D;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [W-1:0]     mcand, mplier;
  logic             busy, done, err;
  logic [2*W-1:0]   product;
  logic [W-1:0]     add_a, add_b, add_sum;
  logic [3:0]       add_carry;

  int checks = 0;
  int errors = 0;

  bcd_seq_multiplier #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_carry(add_carry), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural BCD adder: digit-wise decimal addition.
  function automatic logic [W+3:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
    int c = 0;
    logic [W+3:0] r = '0;
    for (int i = 0; i < D; i++) begin
      int d = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      if (d > 9) begin d = d - 10; c = 1; end else c = 0;
      r[4*i +: 4] = 4'(d);
    end
    r[W+3:W] = 4'(c);
    return r;
  endfunction

  always_comb {add_carry, add_sum} = bcd_add(add_a, add_b);

  // Reference product: schoolbook decimal multiplication on digit arrays.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int acc[2*D];
    int c = 0;
    logic [2*W-1:0] r = '0;
    for (int k = 0; k < 2*D; k++) acc[k] = 0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        acc[i+j] += int'(a[4*i +: 4]) * int'(b[4*j +: 4]);
    for (int k = 0; k < 2*D; k++) begin
      acc[k] += c;
      c = acc[k] / 10;
      r[4*k +: 4] = 4'(acc[k] % 10);
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
    int s = 1 + D;
    for (int j = 0; j < D; j++) s += int'(b[4*j +: 4]);
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Launches one multiply and measures latency (accept edge to done edge)
  // and busy cycles. Optionally pulses a second start while busy and/or a
  // start during the done cycle; both must be ignored.
  task automatic run_mul(input logic [W-1:0] mc, input logic [W-1:0] mp,
                         input int extra_at, input bit start_on_done,
                         output logic [2*W-1:0] prod, output int lat,
                         output int bcnt, output logic e, output bit tmo);
    @(negedge clk);
    mcand = mc; mplier = mp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mcand = '0; mplier = '0;
    bcnt = int'(busy); lat = 0; tmo = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (k == extra_at) begin
        start = 1'b1; mcand = {D{4'h9}}; mplier = {D{4'h9}};
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done) begin tmo = 1'b0; break; end
      bcnt += int'(busy);
    end
    prod = product;
    e = err;
    if (start_on_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", {127'b0, done}, 128'd0);
    check("idle_after_done", {127'b0, busy}, 128'd0);
    check("add_b_idle", {72'b0, add_b}, 128'd0);
  endtask

  typedef struct {
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic [2*W-1:0] prod;
    int             lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] p;
    int             lat, bcnt;
    logic           e;
    bit             tmo;
    logic [W-1:0]   rmc, rmp;

    tbl[0] = '{56'h12345678901234, 56'h0,              112'h0,                            15};
    tbl[1] = '{56'h1,              56'h1,              112'h1,                            16};
    tbl[2] = '{56'h99999999999999, 56'h99999999999999, 112'h9999999999999800000000000001, 141};
    tbl[3] = '{56'h12,             56'h34,             112'h408,                          22};
    tbl[4] = '{56'h0,              56'h99999999999999, 112'h0,                            141};
    tbl[5] = '{56'h12345678901234, 56'h2,              112'h24691357802468,               17};
    tbl[6] = '{56'h99999999999999, 56'h1,              112'h99999999999999,               16};
    tbl[7] = '{56'h50000000000000, 56'h20,             112'h1000000000000000,             17};

    rst_n = 1'b0; start = 1'b0; mcand = '0; mplier = '0;
    #3;
    check("rst_busy",    {127'b0, busy}, 128'd0);
    check("rst_done",    {127'b0, done}, 128'd0);
    check("rst_err",     {127'b0, err},  128'd0);
    check("rst_product", {16'b0, product}, 128'd0);
    check("rst_add_a",   {72'b0, add_a}, 128'd0);
    check("rst_add_b",   {72'b0, add_b}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_mul(tbl[i].mc, tbl[i].mp, -1, 1'b0, p, lat, bcnt, e, tmo);
      check($sformatf("tbl%0d_timeout", i), {127'b0, tmo}, 128'd0);
      check($sformatf("tbl%0d_product", i), {16'b0, p}, {16'b0, tbl[i].prod});
      check($sformatf("tbl%0d_latency", i), 128'(lat), 128'(tbl[i].lat));
      check($sformatf("tbl%0d_busy", i), 128'(bcnt), 128'(tbl[i].lat - 1));
      check($sformatf("tbl%0d_err", i), {127'b0, e}, 128'd0);
    end

    // Start pulsed while busy and again during done: one result, no restart.
    run_mul(56'h12345678901234, 56'h2, 3, 1'b1, p, lat, bcnt, e, tmo);
    check("ign_timeout", {127'b0, tmo}, 128'd0);
    check("ign_product", {16'b0, p}, {16'b0, 112'h24691357802468});
    check("ign_latency", 128'(lat), 128'd17);
    repeat (3) @(posedge clk);
    #1;
    check("ign_no_second_run", {126'b0, busy, done}, 128'd0);

    // Reset in the middle of an ADD run.
    @(negedge clk);
    mcand = {D{4'h9}}; mplier = {D{4'h9}}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midadd_busy", {127'b0, busy}, 128'd1);
    check("midadd_add_b", {72'b0, add_b}, {72'b0, {D{4'h9}}});
    rst_n = 1'b0;
    #1;
    check("abort_busy",    {127'b0, busy}, 128'd0);
    check("abort_done",    {127'b0, done}, 128'd0);
    check("abort_product", {16'b0, product}, 128'd0);
    check("abort_add_a",   {72'b0, add_a}, 128'd0);
    check("abort_add_b",   {72'b0, add_b}, 128'd0);
    check("abort_err",     {127'b0, err},  128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_mul(56'h12345678901234, 56'h2, -1, 1'b0, p, lat, bcnt, e, tmo);
    check("post_rst_product", {16'b0, p}, {16'b0, 112'h24691357802468});
    check("post_rst_latency", 128'(lat), 128'd17);

    // Randomized operands against the reference model.
    for (int n = 0; n < 20; n++) begin
      for (int j = 0; j < D; j++) begin
        rmc[4*j +: 4] = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(0, 9));
        rmp[4*j +: 4] = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(0, 9));
      end
      run_mul(rmc, rmp, -1, 1'b0, p, lat, bcnt, e, tmo);
      check($sformatf("rnd%0d_timeout", n), {127'b0, tmo}, 128'd0);
      check($sformatf("rnd%0d_product", n), {16'b0, p}, {16'b0, ref_mul(rmc, rmp)});
      check($sformatf("rnd%0d_latency", n), 128'(lat), 128'(ref_lat(rmp)));
    end

    // Non-BCD multiplier nibble.
    run_mul(56'h123, 56'h1A, -1, 1'b0, p, lat, bcnt, e, tmo);
    check("nonbcd_timeout", {127'b0, tmo}, 128'd0);
`ifdef BCD_MULT_INPUT_CHECK_EN
    check("nonbcd_err", {127'b0, e}, 128'd1);
    check("nonbcd_product", {16'b0, p}, 128'd0);
    check("nonbcd_latency", 128'(lat), 128'd2);
    check("nonbcd_err_held", {127'b0, err}, 128'd1);
    run_mul(56'h3, 56'h3, -1, 1'b0, p, lat, bcnt, e, tmo);
    check("err_cleared", {127'b0, e}, 128'd0);
    check("err_clear_product", {16'b0, p}, 128'h9);
`else
    check("nonbcd_err", {127'b0, e}, 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
